// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU (alu_mc).
// Defining ALU_DIV_EN adds the DIV state to alu_state_t.
package alu_pkg;

    localparam int unsigned ALU_WIDTH_DEF = 32;
    // Every bit of the quotient is filled with this value on divide-by-zero
    localparam logic        DIV_ZERO_FILL = 1'b1;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_SLL   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SRA   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef ALU_DIV_EN
        ST_DIV  = 2'd3,
`endif
        ST_DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic div_zero;
    } alu_flags_t;

    // Signed overflow of x + y from the operand and result sign bits
    function automatic logic add_ovf(input logic sx, input logic sy, input logic sr);
        return (sx == sy) && (sr != sx);
    endfunction

endpackage

// File: rtl/alu_mc_div_core.sv
// Restoring divider datapath for alu_mc: one quotient bit per step on magnitudes.
// Instantiated only when ALU_DIV_EN is defined.
module alu_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_c_o,
    output logic [WIDTH-1:0] rem_c_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             fits;

    // Dividend bits shift out of quo_q's top while quotient bits shift in at the bottom
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};
    assign fits   = ~trial[WIDTH];
    assign rem_d  = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_d  = {quo_q[WIDTH-2:0], fits};

    assign quo_c_o = quo_d;
    assign rem_c_o = rem_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arith/logic/shift/SLT, iterative multiply and divide,
// valid/ready on both sides. Define ALU_DIV_EN to include the divider.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEF,
    parameter int unsigned SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    alu_state_t         state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    alu_flags_t         flags_q, flags_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;

    alu_op_t          op_e;
    logic             signed_op;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op_e      = alu_op_t'(op);
    assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    // Single-cycle operations, evaluated straight from the request inputs
    logic [WIDTH-1:0] sum, diff, sc_res;
    logic [SH_W-1:0]  shamt;
    alu_flags_t       sc_flags;
    logic             sc_valid;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        sc_res   = '0;
        sc_flags = '0;
        sc_valid = 1'b1;
        case (op_e)
            OP_ADD: begin
                sc_res            = sum;
                sc_flags.overflow = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res            = diff;
                sc_flags.overflow = add_ovf(a[WIDTH-1], ~b[WIDTH-1], diff[WIDTH-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_SRA:  sc_res = WIDTH'($signed(a) >>> shamt);
            OP_SLT:  sc_res = WIDTH'($signed(a) < $signed(b));
            default: sc_valid = 1'b0;
        endcase
        sc_flags.zero = sc_valid && (sc_res == '0);
    end

    // Shift-add multiplier step; the final step also applies the sign
    logic [WIDTH:0]     mul_acc;
    logic [2*WIDTH-1:0] mul_step, mul_fin;

    assign mul_acc  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_step = {mul_acc, prod_q[WIDTH-1:1]};
    assign mul_fin  = neg_q ? -mul_step : mul_step;

`ifdef ALU_DIV_EN
    logic             rneg_q, rneg_d;
    logic             dovf_q, dovf_d;
    logic             div_load, div_step;
    logic [WIDTH-1:0] quo_c, rem_c, quo_fin, rem_fin;

    alu_div_core #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quo_c_o    (quo_c),
        .rem_c_o    (rem_c)
    );

    assign quo_fin = neg_q  ? -quo_c : quo_c;
    assign rem_fin = rneg_q ? -rem_c : rem_c;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
`ifdef ALU_DIV_EN
        rneg_d   = rneg_q;
        dovf_d   = dovf_q;
        div_load = 1'b0;
        div_step = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    neg_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    case (op_e)
                        OP_MULT, OP_MULTU: begin
                            prod_d  = {{WIDTH{1'b0}}, mag_b};
                            mcand_d = mag_a;
                            state_d = ST_MUL;
                        end
`ifdef ALU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            rneg_d = (op_e == OP_DIV) && a[WIDTH-1];
                            dovf_d = (op_e == OP_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
                            if (b == '0) begin
                                res_d            = {WIDTH{DIV_ZERO_FILL}};
                                res_hi_d         = a;
                                flags_d          = '0;
                                flags_d.div_zero = 1'b1;
                                state_d          = ST_DONE;
                            end else begin
                                div_load = 1'b1;
                                state_d  = ST_DIV;
                            end
                        end
`endif
                        default: begin
                            res_d    = sc_res;
                            res_hi_d = '0;
                            flags_d  = sc_flags;
                            state_d  = ST_DONE;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                cnt_d  = cnt_q + CNT_W'(1);
                prod_d = mul_step;
                if (cnt_q == CNT_LAST) begin
                    res_d        = mul_fin[WIDTH-1:0];
                    res_hi_d     = mul_fin[2*WIDTH-1:WIDTH];
                    flags_d      = '0;
                    flags_d.zero = (mul_fin[WIDTH-1:0] == '0);
                    state_d      = ST_DONE;
                end
            end
`ifdef ALU_DIV_EN
            ST_DIV: begin
                cnt_d    = cnt_q + CNT_W'(1);
                div_step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_d            = quo_fin;
                    res_hi_d         = rem_fin;
                    flags_d          = '0;
                    flags_d.zero     = (quo_fin == '0);
                    flags_d.overflow = dovf_q;
                    state_d          = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            res_hi_q    <= '0;
            flags_q     <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            neg_q       <= 1'b0;
`ifdef ALU_DIV_EN
            rneg_q      <= 1'b0;
            dovf_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            res_hi_q    <= res_hi_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            neg_q       <= neg_d;
`ifdef ALU_DIV_EN
            rneg_q      <= rneg_d;
            dovf_q      <= dovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign zero      = flags_q.zero;
    assign overflow  = flags_q.overflow;
    assign div_zero  = flags_q.div_zero;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, multi-cycle corner sequences,
// and randomized ops against a plain-arithmetic reference model.
module tb_alu_mc;

    localparam int unsigned W       = 32;
    localparam int          MUL_LAT = W + 1;

    logic          clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic          zero, overflow, div_zero;
    logic [W-1:0]  a, b, result, result_hi;
    logic [3:0]    op;
    int            n_pass, n_total;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        ov;
        logic        dz;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic vec_t mkv(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] res, input logic [31:0] hi,
                                 input logic z, input logic ov, input logic dz, input int lat);
        vec_t v;
        v.op = o; v.a = x; v.b = y;
        v.e.res = res; v.e.hi = hi; v.e.z = z; v.e.ov = ov; v.e.dz = dz; v.e.lat = lat;
        return v;
    endfunction

    // Reference model: direct signed/unsigned arithmetic on 64-bit integers
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, p;
        logic [63:0] u;
        bit          vld;
        e.res = '0; e.hi = '0; e.z = 1'b0; e.ov = 1'b0; e.dz = 1'b0; e.lat = 1;
        vld = 1'b1;
        sx  = longint'(int'(x));
        sy  = longint'(int'(y));
        case (o)
            4'h0: begin p = sx + sy; e.res = x + y; e.ov = (p != longint'(int'(p[31:0]))); end
            4'h1: begin p = sx - sy; e.res = x - y; e.ov = (p != longint'(int'(p[31:0]))); end
            4'h2: e.res = x & y;
            4'h3: e.res = x | y;
            4'h4: e.res = x << y[4:0];
            4'h5: e.res = x >> y[4:0];
            4'h6: e.res = 32'(int'(x) >>> y[4:0]);
            4'h7: e.res = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'h8: begin p = sx * sy; u = 64'(p); e.res = u[31:0]; e.hi = u[63:32]; e.lat = MUL_LAT; end
            4'h9: begin u = 64'(x) * 64'(y); e.res = u[31:0]; e.hi = u[63:32]; e.lat = MUL_LAT; end
`ifdef ALU_DIV_EN
            4'hA: begin
                if (y == 0) begin
                    e.res = 32'hFFFF_FFFF; e.hi = x; e.dz = 1'b1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.res = 32'h8000_0000; e.ov = 1'b1; e.lat = MUL_LAT;
                end else begin
                    e.res = 32'(int'(x) / int'(y)); e.hi = 32'(int'(x) % int'(y)); e.lat = MUL_LAT;
                end
            end
            4'hB: begin
                if (y == 0) begin
                    e.res = 32'hFFFF_FFFF; e.hi = x; e.dz = 1'b1;
                end else begin
                    e.res = x / y; e.hi = x % y; e.lat = MUL_LAT;
                end
            end
`endif
            default: vld = 1'b0;
        endcase
        e.z = vld && (e.res == 0) && !e.dz;
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op from a negedge, scramble inputs after accept, wait for and take the result
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output exp_t got);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        check("in_ready_before_req", 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        in_valid = 1'b0; op = 4'($urandom); a = 32'($urandom); b = 32'($urandom);
        got.lat = 1;
        while (!out_valid && got.lat < 200) begin @(negedge clk); got.lat++; end
        got.res = result; got.hi = result_hi; got.z = zero; got.ov = overflow; got.dz = div_zero;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic compare(input string tag, input exp_t got, input exp_t exp);
        check({tag, ".result"},    64'(got.res), 64'(exp.res));
        check({tag, ".result_hi"}, 64'(got.hi),  64'(exp.hi));
        check({tag, ".zero"},      64'(got.z),   64'(exp.z));
        check({tag, ".overflow"},  64'(got.ov),  64'(exp.ov));
        check({tag, ".div_zero"},  64'(got.dz),  64'(exp.dz));
        check({tag, ".latency"},   64'(got.lat), 64'(exp.lat));
    endtask

    initial begin
        exp_t got;
        exp_t e;
        int   seen;
        logic [3:0]  ro;
        logic [31:0] rx, ry;

        clk = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0; n_pass = 0; n_total = 0;

        vecs.push_back(mkv(4'h0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 32'h0,         1'b0, 1'b1, 1'b0, 1));
        vecs.push_back(mkv(4'h8, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, MUL_LAT));
        vecs.push_back(mkv(4'h8, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, MUL_LAT));
        vecs.push_back(mkv(4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, MUL_LAT));
        vecs.push_back(mkv(4'h8, 32'h0,         32'h12345,     32'h0,         32'h0,         1'b1, 1'b0, 1'b0, MUL_LAT));
        vecs.push_back(mkv(4'h1, 32'h5,         32'h5,         32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 1));
        vecs.push_back(mkv(4'h1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 32'h0,         1'b0, 1'b1, 1'b0, 1));
        vecs.push_back(mkv(4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0,         1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mkv(4'h3, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 32'h0,         1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mkv(4'h4, 32'h1,         32'h24,        32'h10,        32'h0,         1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mkv(4'h5, 32'h8000_0000, 32'h1F,        32'h1,         32'h0,         1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mkv(4'h7, 32'hFFFF_FFFF, 32'h1,         32'h1,         32'h0,         1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mkv(4'h7, 32'h1,         32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 1));
        vecs.push_back(mkv(4'hC, 32'h5,         32'h7,         32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1));
`ifdef ALU_DIV_EN
        vecs.push_back(mkv(4'hA, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, MUL_LAT));
        vecs.push_back(mkv(4'hB, 32'h7,         32'h0,         32'hFFFF_FFFF, 32'h7,         1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mkv(4'hA, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0, 1'b1, 1'b0, MUL_LAT));
        vecs.push_back(mkv(4'hB, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 1'b0, MUL_LAT));
        vecs.push_back(mkv(4'hA, 32'h3,         32'h5,         32'h0,         32'h3,         1'b1, 1'b0, 1'b0, MUL_LAT));
`else
        vecs.push_back(mkv(4'hA, 32'h7,         32'h2,         32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mkv(4'hB, 32'h7,         32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1));
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd1);
        check("rst.result",    64'(result),    64'd0);
        check("rst.result_hi", 64'(result_hi), 64'd0);
        check("rst.flags",     64'({zero, overflow, div_zero}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, got);
            compare($sformatf("vec%0d_op%0h", i, vecs[i].op), got, vecs[i].e);
        end

        // SRA then a 5-cycle stall with a request that must be ignored
        in_valid = 1'b1; op = 4'h6; a = 32'h8000_0000; b = 32'h21;
        @(negedge clk);
        check("stall.first_valid", 64'(out_valid), 64'd1);
        check("stall.sra_result",  64'(result),    64'hC000_0000);
        in_valid = 1'b1; op = 4'h0; a = 32'h1; b = 32'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d.out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d.in_ready", i),  64'(in_ready),  64'd0);
            check($sformatf("stall%0d.result", i),    64'(result),    64'hC000_0000);
            check($sformatf("stall%0d.result_hi", i), 64'(result_hi), 64'd0);
            check($sformatf("stall%0d.flags", i),     64'({zero, overflow, div_zero}), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall.release_in_ready",  64'(in_ready),  64'd1);
        check("stall.release_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("stall.not_queued", 64'(out_valid), 64'd0);

        // Reset in the middle of a multiply
        in_valid = 1'b1; op = 4'h8; a = 32'h1234; b = 32'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst.busy_in_ready", 64'(in_ready), 64'd0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.in_ready",  64'(in_ready),  64'd1);
        check("midrst.result",    64'(result),    64'd0);
        check("midrst.result_hi", 64'(result_hi), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst.no_stale_result", 64'(seen), 64'd0);
        run_op(4'h0, 32'h2, 32'h3, got);
        e.res = 32'h5; e.hi = '0; e.z = 1'b0; e.ov = 1'b0; e.dz = 1'b0; e.lat = 1;
        compare("midrst.add", got, e);

        // Randomized ops against the reference model
        for (int i = 0; i < 80; i++) begin
            ro = 4'($urandom_range(0, 15));
            rx = rnd_operand();
            ry = rnd_operand();
            run_op(ro, rx, ry, got);
            compare($sformatf("rnd%0d_op%0h_a%h_b%h", i, ro, rx, ry), got, model(ro, rx, ry));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
